// File: rtl/lsu.sv
// Load/store unit: one outstanding request, range/alignment checks, programmable
// pre-access wait, extended load data or error code on the response channel.
//
// state | meaning
// IDLE  | ready for a request; classify and latch on accept
// WAIT  | counting down the wait cycles; memory access when the counter is zero
// RESP  | response presented, held until resp_ready
module lsu #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(32'h80000000),
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = ADDR_WIDTH'(32'h5000),
    parameter int                    LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  mem_we,
    output logic [1:0]            mem_format,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_F3    = 2'b11;

    // One extra bit so a region ending at the top of the address space cannot wrap.
    localparam logic [ADDR_WIDTH:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    state_t                state;
    logic [3:0]            cnt;
    logic                  wen_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  funct3_ok;
    logic                  misaligned;
    logic                  out_of_range;
    logic [1:0]            req_err;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        if (req_wen)
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                        (req_funct3 == 3'b100) || (req_funct3 == 3'b101);

        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase

        out_of_range = (req_addr < MEM_BASE) || ({1'b0, req_addr} >= MEM_END);

        if (!funct3_ok)
            req_err = ERR_F3;
        else if (misaligned)
            req_err = ERR_ALIGN;
        else if (out_of_range)
            req_err = ERR_FAULT;
        else
            req_err = ERR_OK;
    end

    // The RAM returns unmasked data; narrow accesses are masked and extended here.
    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wen_q      <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_err != ERR_OK) begin
                            resp_err   <= req_err;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            cnt   <= 4'(LATENCY);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_rdata <= wen_q ? '0 : load_data;
                        resp_err   <= ERR_OK;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // rst gates the strobe so a reset landing on the access cycle never writes.
    assign mem_we     = (state == WAIT) && (cnt == 4'd0) && wen_q && !rst;
    assign mem_format = funct3_q[1:0];
    assign mem_addr   = addr_q;
    assign mem_raddr  = addr_q;
    assign mem_wdata  = wdata_q;

endmodule
